// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the byte-serial memory controller.
package mem_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StIfRd,
    StMemRd,
    StMemWr,
    StDone
  } state_e;

  // Reads need one extra slot because RAM data arrives a cycle after its address.
  localparam logic [2:0] RdLastCnt = 3'd4;
  localparam logic [2:0] WrLastCnt = 3'd3;

endpackage

// File: rtl/mem_ctrl_byte_shifter.sv
// Little-endian byte assemble (read path) and byte select (write path) for a 32-bit word.
module mem_ctrl_byte_shifter (
  input  logic [1:0]  rd_idx_i,
  input  logic [31:0] rd_word_i,
  input  logic [7:0]  rd_byte_i,
  output logic [31:0] rd_word_o,
  input  logic [1:0]  wr_idx_i,
  input  logic [31:0] wr_word_i,
  output logic [7:0]  wr_byte_o
);

  always_comb begin
    rd_word_o = rd_word_i;
    rd_word_o[{rd_idx_i, 3'b000} +: 8] = rd_byte_i;
    wr_byte_o = wr_word_i[{wr_idx_i, 3'b000} +: 8];
  end

endmodule

// File: rtl/mem_ctrl.sv
// Arbitrates instruction-fetch and data ports onto a byte-wide single-port synchronous RAM,
// splitting each 32-bit access into four little-endian byte transfers.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W    = 17,
  parameter int unsigned DATA_PRIO = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_i,
  input  logic [31:0]       if_addr_i,
  input  logic              if_abort_i,
  output logic [31:0]       if_data_o,
  output logic              if_done_o,
  input  logic              mem_req_i,
  input  logic              mem_we_i,
  input  logic [3:0]        mem_sel_i,
  input  logic [31:0]       mem_addr_i,
  input  logic [31:0]       mem_wdata_i,
  output logic [31:0]       mem_rdata_o,
  output logic              mem_done_o,
  output logic              stallreq_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic              ram_wr_o,
  output logic [7:0]        ram_dout_o,
  input  logic [7:0]        ram_din_i
);

  state_e            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [3:0]        sel_q;
  logic              dest_if_q;
  logic [31:0]       rbuf_q;
  logic [31:0]       if_data_q;
  logic [31:0]       mem_rdata_q;

  logic        take_mem, take_if, accept;
  logic        rd_state, abort_now, rd_last;
  logic [31:0] rd_word;
  logic [7:0]  wr_byte;
  logic        unused_addr_bits;

  assign unused_addr_bits = ^{if_addr_i[31:ADDR_W], mem_addr_i[31:ADDR_W]};

  // A fetch that would win while being aborted blocks the accept entirely.
  assign take_mem  = mem_req_i && (!if_req_i || (DATA_PRIO != 0));
  assign take_if   = if_req_i && !take_mem && !if_abort_i;
  assign accept    = (state_q == StIdle) && (take_mem || take_if);
  assign rd_state  = (state_q == StIfRd) || (state_q == StMemRd);
  assign abort_now = (state_q == StIfRd) && if_abort_i;
  assign rd_last   = rd_state && !abort_now && (cnt_q == RdLastCnt);

  mem_ctrl_byte_shifter u_byte_shifter (
    .rd_idx_i  (cnt_q[1:0] - 2'd1),
    .rd_word_i (rbuf_q),
    .rd_byte_i (ram_din_i),
    .rd_word_o (rd_word),
    .wr_idx_i  (cnt_q[1:0]),
    .wr_word_i (wdata_q),
    .wr_byte_o (wr_byte)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (take_mem) begin
          state_d = mem_we_i ? StMemWr : StMemRd;
        end else if (take_if) begin
          state_d = StIfRd;
        end
      end
      StIfRd, StMemRd: begin
        if (abort_now) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (cnt_q == RdLastCnt) begin
          state_d = StDone;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      StMemWr: begin
        if (cnt_q == WrLastCnt) begin
          state_d = StDone;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    ram_addr_o = '0;
    ram_wr_o   = 1'b0;
    ram_dout_o = '0;
    if ((rd_state && (cnt_q != RdLastCnt)) || (state_q == StMemWr)) begin
      ram_addr_o = addr_q + ADDR_W'(cnt_q);
    end
    if (state_q == StMemWr) begin
      ram_wr_o   = sel_q[cnt_q[1:0]];
      ram_dout_o = wr_byte;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      sel_q       <= '0;
      dest_if_q   <= 1'b0;
      rbuf_q      <= '0;
      if_data_q   <= '0;
      mem_rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        addr_q    <= take_mem ? mem_addr_i[ADDR_W-1:0] : if_addr_i[ADDR_W-1:0];
        wdata_q   <= mem_wdata_i;
        sel_q     <= mem_sel_i;
        dest_if_q <= !take_mem;
      end
      if (rd_state && !abort_now && (cnt_q != 3'd0)) begin
        rbuf_q <= rd_word;
      end
      // Port result registers only change on a completed read.
      if (rd_last) begin
        if (dest_if_q) begin
          if_data_q <= rd_word;
        end else begin
          mem_rdata_q <= rd_word;
        end
      end
    end
  end

  assign if_data_o   = if_data_q;
  assign mem_rdata_o = mem_rdata_q;
  assign if_done_o   = (state_q == StDone) && dest_if_q;
  assign mem_done_o  = (state_q == StDone) && !dest_if_q;
  assign stallreq_o  = rst && ((state_q != StIdle) || if_req_i || mem_req_i);

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl against a byte-wide synchronous RAM model.
module tb_mem_ctrl;

  localparam int unsigned AW = 17;

  typedef struct {
    logic        is_mem;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    int          exp_lat;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          if_req = 1'b0;
  logic [31:0]   if_addr = '0;
  logic          if_abort = 1'b0;
  logic [31:0]   if_data;
  logic          if_done;
  logic          mem_req = 1'b0;
  logic          mem_we = 1'b0;
  logic [3:0]    mem_sel = '0;
  logic [31:0]   mem_addr = '0;
  logic [31:0]   mem_wdata = '0;
  logic [31:0]   mem_rdata;
  logic          mem_done;
  logic          stallreq;
  logic [AW-1:0] ram_addr;
  logic          ram_wr;
  logic [7:0]    ram_dout;
  logic [7:0]    ram_din;

  logic [7:0]    ram [0:(1<<AW)-1];
  logic          bd_we = 1'b0;
  logic [AW-1:0] bd_addr = '0;
  logic [7:0]    bd_data = '0;

  int checks = 0;
  int errors = 0;
  vec_t vecs[8];

  mem_ctrl #(
    .ADDR_W    (AW),
    .DATA_PRIO (1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .if_req_i    (if_req),
    .if_addr_i   (if_addr),
    .if_abort_i  (if_abort),
    .if_data_o   (if_data),
    .if_done_o   (if_done),
    .mem_req_i   (mem_req),
    .mem_we_i    (mem_we),
    .mem_sel_i   (mem_sel),
    .mem_addr_i  (mem_addr),
    .mem_wdata_i (mem_wdata),
    .mem_rdata_o (mem_rdata),
    .mem_done_o  (mem_done),
    .stallreq_o  (stallreq),
    .ram_addr_o  (ram_addr),
    .ram_wr_o    (ram_wr),
    .ram_dout_o  (ram_dout),
    .ram_din_i   (ram_din)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bd_we) ram[bd_addr] <= bd_data;
    else if (ram_wr) ram[ram_addr] <= ram_dout;
    ram_din <= ram[ram_addr];
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic poke(input logic [AW-1:0] a, input logic [7:0] d);
    bd_addr = a;
    bd_data = d;
    bd_we   = 1'b1;
    @(negedge clk);
    bd_we   = 1'b0;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int            cyc;
    bit            got, addr_ok, wr_ok, other_ok;
    logic [AW-1:0] exp_a;
    string         nm;
    nm = $sformatf("vec%0d", idx);
    if_addr   = v.addr;
    mem_addr  = v.addr;
    mem_we    = v.we;
    mem_sel   = v.sel;
    mem_wdata = v.wdata;
    if_req    = !v.is_mem;
    mem_req   = v.is_mem;
    got = 0; cyc = 0; addr_ok = 1; wr_ok = 1; other_ok = 1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      cyc = i;
      if (v.is_mem ? if_done : mem_done) other_ok = 0;
      if (v.is_mem ? mem_done : if_done) begin
        got = 1;
        break;
      end
      if (i <= 4) begin
        exp_a = AW'(v.addr + 32'(i - 1));
        if (ram_addr !== exp_a) addr_ok = 0;
        if (v.is_mem && v.we) begin
          if (ram_wr !== v.sel[i-1]) wr_ok = 0;
          if (v.sel[i-1] && (ram_dout !== v.wdata[8*(i-1) +: 8])) wr_ok = 0;
        end else if (ram_wr !== 1'b0) begin
          wr_ok = 0;
        end
      end
    end
    if_req  = 1'b0;
    mem_req = 1'b0;
    check({nm, " done seen"}, 32'(got), 32'd1);
    check({nm, " latency"}, cyc, v.exp_lat);
    check({nm, " addr seq"}, 32'(addr_ok), 32'd1);
    check({nm, " write strobes"}, 32'(wr_ok), 32'd1);
    check({nm, " other port quiet"}, 32'(other_ok), 32'd1);
    check({nm, " ram idle in done"}, {ram_wr, 14'd0, ram_addr}, 32'd0);
    if (!(v.is_mem && v.we)) begin
      check({nm, " rdata"}, v.is_mem ? mem_rdata : if_data, v.exp_rdata);
    end
    @(negedge clk);
    check({nm, " done/stall cleared"}, {if_done, mem_done, stallreq}, 32'd0);
  endtask

  initial begin
    int  mem_cyc, if_cyc, n;
    bit  stall_ok, if_seen, done_seen;
    vec_t rv;

    vecs[0] = '{1'b0, 1'b0, 4'h0, 32'h0000_0100, 32'h0, 32'h00A0_0513, 6};
    vecs[1] = '{1'b1, 1'b1, 4'b0110, 32'h0000_0200, 32'hDEAD_BEEF, 32'h0, 5};
    vecs[2] = '{1'b1, 1'b0, 4'h0, 32'h0000_0200, 32'h0, 32'h44AD_BE11, 6};
    vecs[3] = '{1'b0, 1'b0, 4'h0, 32'h0001_FFFE, 32'h0, 32'hDDCC_BBAA, 6};
    vecs[4] = '{1'b1, 1'b1, 4'hF, 32'h0000_0300, 32'h0123_4567, 32'h0, 5};
    vecs[5] = '{1'b1, 1'b0, 4'h0, 32'h0000_0300, 32'h0, 32'h0123_4567, 6};
    vecs[6] = '{1'b1, 1'b1, 4'b1001, 32'h0001_FFFF, 32'hA1B2_C3D4, 32'h0, 5};
    vecs[7] = '{1'b0, 1'b0, 4'h0, 32'h0001_FFFF, 32'h0, 32'hA1DD_CCD4, 6};

    // Preload RAM while the controller is held in reset.
    @(negedge clk);
    poke(17'h00100, 8'h13); poke(17'h00101, 8'h05); poke(17'h00102, 8'hA0);
    poke(17'h00103, 8'h00);
    poke(17'h00200, 8'h11); poke(17'h00201, 8'h22); poke(17'h00202, 8'h33);
    poke(17'h00203, 8'h44);
    poke(17'h1FFFE, 8'hAA); poke(17'h1FFFF, 8'hBB); poke(17'h00000, 8'hCC);
    poke(17'h00001, 8'hDD); poke(17'h00002, 8'h00);
    for (int a = 0; a < 4; a++) begin
      poke(AW'(32'h300 + a), 8'h00);
      poke(AW'(32'h400 + a), 8'h00);
    end

    check("reset if_data", if_data, 32'h0);
    check("reset mem_rdata", mem_rdata, 32'h0);
    check("reset flags", {if_done, mem_done, stallreq, ram_wr}, 32'h0);
    check("reset ram_addr", 32'(ram_addr), 32'h0);
    check("reset ram_dout", 32'(ram_dout), 32'h0);
    rst = 1'b1;
    @(negedge clk);

    for (int k = 0; k < 8; k++) run_vec(k, vecs[k]);

    // Simultaneous requests: data port first, fetch accepted after DONE+IDLE.
    if_addr = 32'h100; mem_addr = 32'h200; mem_we = 1'b0;
    if_req = 1'b1; mem_req = 1'b1;
    mem_cyc = 0; if_cyc = 0; stall_ok = 1;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (!stallreq) stall_ok = 0;
      if (mem_done && mem_cyc == 0) begin
        mem_cyc = i;
        mem_req = 1'b0;
      end
      if (if_done) begin
        if_cyc = i;
        if_req = 1'b0;
        break;
      end
    end
    if_req = 1'b0; mem_req = 1'b0;
    check("contend mem done cycle", mem_cyc, 6);
    check("contend if done cycle", if_cyc, 13);
    check("contend stall continuous", 32'(stall_ok), 32'd1);
    check("contend mem_rdata", mem_rdata, 32'h44AD_BE11);
    check("contend if_data", if_data, 32'h00A0_0513);
    @(negedge clk);

    // Abort at cnt 2 of a fetch with a data read queued behind it.
    if_addr = 32'h100; mem_addr = 32'h300; mem_we = 1'b0; if_req = 1'b1;
    if_seen = 0;
    @(negedge clk);
    if_seen |= if_done;
    mem_req = 1'b1;
    @(negedge clk);
    if_seen |= if_done;
    @(negedge clk);
    if_seen |= if_done;
    check("abort pre addr", 32'(ram_addr), 32'h102);
    if_abort = 1'b1; if_req = 1'b0;
    @(negedge clk);
    if_seen |= if_done;
    if_abort = 1'b0;
    check("abort idle addr", 32'(ram_addr), 32'h0);
    check("abort idle stall", 32'(stallreq), 32'd1);
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if_seen |= if_done;
      if (mem_done) begin
        n = i;
        break;
      end
    end
    mem_req = 1'b0;
    check("abort queued mem latency", n, 6);
    check("abort no if_done", 32'(if_seen), 32'd0);
    check("abort if_data held", if_data, 32'h00A0_0513);
    check("abort mem_rdata", mem_rdata, 32'h0123_4567);
    @(negedge clk);

    // Abort coinciding with a winning fetch in IDLE: nothing is accepted.
    if_addr = 32'h100; if_req = 1'b1; if_abort = 1'b1;
    @(negedge clk);
    check("idle abort no accept 1", 32'(ram_addr), 32'h0);
    @(negedge clk);
    check("idle abort no accept 2", 32'(ram_addr), 32'h0);
    if_req = 1'b0; if_abort = 1'b0;
    @(negedge clk);
    check("idle abort no done", {if_done, mem_done, stallreq}, 32'h0);

    // Reset during cnt 2 of a write: bytes 0 and 1 land, then everything clears.
    mem_addr = 32'h400; mem_we = 1'b1; mem_sel = 4'hF; mem_wdata = 32'h5566_7788;
    mem_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check("rstmid pre addr/wr", {ram_wr, 14'd0, ram_addr}, {1'b1, 14'd0, 17'h00402});
    rst = 1'b0;
    #1;
    check("rstmid ram_wr", 32'(ram_wr), 32'd0);
    check("rstmid data regs", if_data | mem_rdata, 32'h0);
    check("rstmid flags/addr", {if_done, mem_done, stallreq, 12'd0, ram_addr}, 32'h0);
    mem_req = 1'b0; mem_we = 1'b0;
    done_seen = 0;
    repeat (3) begin
      @(negedge clk);
      done_seen |= (if_done | mem_done);
    end
    rst = 1'b1;
    check("rstmid no done", 32'(done_seen), 32'd0);
    @(negedge clk);
    rv = '{1'b1, 1'b0, 4'h0, 32'h0000_0400, 32'h0, 32'h0000_7788, 6};
    run_vec(8, rv);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Arbitrates the core's instruction-fetch port (pc_reg/if_id side) and data port (MEM stage side) onto one byte-wide, single-port synchronous RAM.
- Sits directly downstream of openmips: drives rom_data_i and mem_data_i, and consumes the rom/mem address and control outputs.
- Converts each 32-bit access into four sequential byte transfers, little-endian.
- Raises a stall request to ctrl while any access is in flight.

Parameters:
- ADDR_W, 17, width of the external RAM byte address.
- DATA_PRIO, 1, 1 = data port wins simultaneous requests; 0 = instruction port wins.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-low reset
- if_req_i  in  1  instruction read request, held until if_done_o
- if_addr_i  in  32  instruction byte address
- if_abort_i  in  1  branch taken: cancel an in-flight fetch
- if_data_o  out  32  fetched instruction
- if_done_o  out  1  one-cycle pulse, if_data_o valid
- mem_req_i  in  1  data request, held until mem_done_o
- mem_we_i  in  1  1 = write, 0 = read
- mem_sel_i  in  4  byte enables for writes; bit k enables byte addr+k
- mem_addr_i  in  32  data byte address
- mem_wdata_i  in  32  write data
- mem_rdata_o  out  32  read data
- mem_done_o  out  1  one-cycle pulse, access complete
- stallreq_o  out  1  1 while state != IDLE, or while any req is high in IDLE
- ram_addr_o  out  ADDR_W  RAM byte address
- ram_wr_o  out  1  RAM write strobe
- ram_dout_o  out  8  byte to RAM
- ram_din_i  in  8  byte from RAM, valid the cycle after its address

Behaviour:
- Reset (rst low, async): state IDLE, cnt 0; all outputs 0, including data registers.
- States: IDLE, IF_RD, MEM_RD, MEM_WR, DONE.
- IDLE arbitration:
  - Sample requests at a clock edge.
  - Only one request high: take it.
  - Both high: DATA_PRIO selects the winner.
  - On accept, latch addr, wdata, sel and we; cnt <= 0.
- Read states (IF_RD, MEM_RD), cnt runs 0..4:
  - cnt k<4: ram_addr_o = (latched addr + k)[ADDR_W-1:0].
  - cnt k>=1: capture ram_din_i into result byte k-1.
  - At cnt 4: go to DONE.
- MEM_WR, cnt runs 0..3:
  - ram_addr_o = addr+k; ram_dout_o = wdata[8k+7:8k]; ram_wr_o = sel[k].
  - A cycle with a cleared sel bit still occupies a slot.
  - After cnt 3: go to DONE.
- DONE (exactly one cycle):
  - Matching done pulse high; result register stable.
  - if_data_o / mem_rdata_o hold their value until the next completion on that port.
  - Next state is IDLE; no request is accepted in DONE.
  - Requester must drop req by the end of the DONE cycle unless it issues a new request.
- Latency, accept edge to done: reads 6 cycles; writes 5 cycles.
- ram_wr_o is 0 outside MEM_WR. ram_addr_o is 0 in IDLE and DONE.
- if_abort_i:
  - In IF_RD: return to IDLE next edge, no if_done_o, if_data_o unchanged.
  - In IDLE with the fetch winning the same edge: no accept.
  - Ignored in other states.
- Address wrap: addr+k is truncated to ADDR_W bits, so 0x1FFFF+1 goes to 0.
- Requests dropped mid-transfer (other than via abort) are ignored; the transfer completes.
- Reset asserted mid-operation: immediate return to IDLE; the partial write stays in RAM; no done pulse.

Decomposition:
- Constants in defines.v: state encodings, `RamAddrBus, `ByteBus.
- Optional sub-module byte_shifter: 4-byte assemble/disassemble indexed by cnt.
- FSM and arbitration stay in mem_ctrl.

Test Plan:
- Instruction read: RAM[0x100..0x103] = 13,05,A0,00; if_req_i, addr 0x100 -> if_done_o 6 cycles after accept; if_data_o = 0x00A00513; ram_addr_o steps 0x100..0x103.
- Masked write: mem_we_i=1, sel=4'b0110, addr 0x200, wdata 0xDEADBEEF -> ram_wr_o high only at 0x201 and 0x202 with bytes BE, AD; mem_done_o 5 cycles after accept; bytes 0x200 and 0x203 unchanged.
- Contention, DATA_PRIO=1: both reqs high in the same cycle -> MEM_RD served first; IF_RD accepted the cycle after DONE; stallreq_o continuous throughout.
- Abort: if_abort_i at cnt 2 of a fetch -> IDLE next cycle; no if_done_o; queued mem_req_i accepted the following edge.
- Wrap: read at addr 0x1FFFE -> ram_addr_o sequence 1FFFE, 1FFFF, 00000, 00001.
- Reset: rst low during cnt 2 of MEM_WR -> ram_wr_o 0 immediately; no done pulse; outputs 0; after release, a read of the same address returns the partially written bytes.
